// File: rtl/risc_mem_pkg.sv
// risc_mem_pkg: shared FSM state and owner encodings for the memory arbiter
package risc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int CTR_W = 4;

endpackage

// File: rtl/risc_mem_wait_ctr.sv
// risc_mem_wait_ctr: loadable down-counter timing the fixed memory latency
//   clk, rst  : clock, asynchronous active-low reset
//   load, val : load val into the counter
//   dec       : decrement by one (holds at zero)
//   is_one    : counter currently reads 1
module risc_mem_wait_ctr
    import risc_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CTR_W-1:0] val,
    output logic             is_one
);

    logic [CTR_W-1:0] cnt;

    assign is_one = cnt == CTR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= val;
        else if (dec && cnt != '0)
            cnt <= cnt - CTR_W'(1);
    end

endmodule

// File: rtl/risc_mem_arbiter.sv
// risc_mem_arbiter: shares one single-port memory between instruction fetch and load/store
//   clk, rst                       : clock, asynchronous active-low reset
//   if_req/if_addr                 : fetch request, held until if_ack
//   if_rdata/if_ack                : fetched word and one-cycle completion pulse
//   ls_req/ls_we/ls_addr/ls_wdata  : load/store request, held until ls_ack
//   ls_rdata/ls_ack                : load data and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory macro interface
//   busy                           : arbiter is not idle
module risc_mem_arbiter
    import risc_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t        state;
    owner_t        owner;
    logic          own_we;
    logic [SW-1:0] starve;
    logic          is_one;
    logic          pick_ls;

    // Load/store normally wins; fetch is forced once it has been passed over STARVE_MAX times.
    assign pick_ls = ls_req && !(if_req && starve >= SW'(STARVE_MAX));
    assign busy    = state != IDLE;

    risc_mem_wait_ctr u_wait_ctr (
        .clk    (clk),
        .rst    (rst),
        .load   (state == ISSUE),
        .dec    (state == WAIT),
        .val    (CTR_W'(MEM_LAT)),
        .is_one (is_one)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            own_we    <= 1'b0;
            starve    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            ls_ack <= 1'b0;
            case (state)
                IDLE: if (if_req || ls_req) begin
                    owner     <= pick_ls ? OWN_LS : OWN_IF;
                    own_we    <= pick_ls && ls_we;
                    mem_we    <= pick_ls && ls_we;
                    mem_addr  <= pick_ls ? ls_addr : if_addr;
                    mem_wdata <= pick_ls ? ls_wdata : '0;
                    mem_en    <= 1'b1;
                    starve    <= !pick_ls ? '0 :
                                 (if_req && starve < SW'(STARVE_MAX)) ? starve + SW'(1) : starve;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= WAIT;
                end
                // The counter reads 1 exactly in the cycle mem_rdata is valid.
                WAIT: if (is_one) begin
                    if (owner == OWN_IF) begin
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                    end else begin
                        if (!own_we)
                            ls_rdata <= mem_rdata;
                        ls_ack <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: state <= IDLE;
            endcase
        end
    end

endmodule
